// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-256 counter-mode controller: widths, state encoding
// and the partial-block byte mask used when CTR_PARTIAL_EN is defined.
package aes_ctr_pkg;

    localparam int BLOCK_W       = 128;
    localparam int KEY_W         = 256;
    localparam int CTR_W_DEFAULT = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_READY     = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_CORE = 3'd3;
    localparam logic [2:0] ST_OUTPUT    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_READY     = ST_READY,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_CORE = ST_WAIT_CORE,
        S_OUTPUT    = ST_OUTPUT
    } state_t;

    // Byte 0 is the most significant byte; nbytes == 0 means the whole block is valid.
    function automatic logic [BLOCK_W-1:0] mask_tail(input logic [BLOCK_W-1:0] blk,
                                                     input logic [3:0] nbytes);
        logic [BLOCK_W-1:0] res;
        res = blk;
        for (int i = 0; i < 16; i++) begin
            if (nbytes != 4'd0 && i >= int'(nbytes)) begin
                res[BLOCK_W-1-8*i -: 8] = 8'h00;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_ctr_controller_ctr_inc.sv
// Combinational increment of the low CTR_W bits of a 128-bit counter block; the
// upper bits pass through unchanged and wrap flags an all-ones field.
module ctr_inc
    import aes_ctr_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEFAULT
) (
    input  logic [BLOCK_W-1:0] block,
    output logic [BLOCK_W-1:0] next_block,
    output logic               wrap
);

    logic [CTR_W-1:0] field;
    logic [CTR_W-1:0] field_inc;

    assign field     = block[CTR_W-1:0];
    assign field_inc = field + CTR_W'(1);
    assign wrap      = &field;

    generate
        if (CTR_W < BLOCK_W) begin : g_part
            assign next_block = {block[BLOCK_W-1:CTR_W], field_inc};
        end else begin : g_full
            assign next_block = field_inc;
        end
    endgenerate

endmodule

// File: rtl/aes_ctr_controller.sv
// Counter-mode sequencer in front of a shared AES-256 core: one core encryption per
// accepted block, keystream XOR, registered outputs. Optional feature: CTR_PARTIAL_EN.
module aes_ctr_controller
    import aes_ctr_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CTR_PARTIAL_EN
    input  logic               din_last,
    input  logic [3:0]         din_nbytes,
    output logic               dout_last,
`endif
    input  logic [KEY_W-1:0]   key_i,
    input  logic               key_load,
    input  logic [BLOCK_W-1:0] iv_i,
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [BLOCK_W-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_block,
    output logic               core_start,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_result,
    output logic               busy,
    output logic               ctr_wrap
);

    state_t             state;
    state_t             state_next;
    logic               key_cap;
    logic               iv_cap;
    logic               accept;
    logic               core_cap;
    logic               out_hs;
    logic               last_blk;
    logic [BLOCK_W-1:0] ctr_reg;
    logic [BLOCK_W-1:0] ctr_next;
    logic [BLOCK_W-1:0] inc_block;
    logic               inc_wrap;
    logic               wrap_next;
    logic [BLOCK_W-1:0] data_reg;
    logic [BLOCK_W-1:0] result;

    ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
        .block      (ctr_reg),
        .next_block (inc_block),
        .wrap       (inc_wrap)
    );

`ifdef CTR_PARTIAL_EN
    logic       last_reg;
    logic [3:0] nbytes_reg;

    assign last_blk = last_reg;
    assign result   = mask_tail(core_result ^ data_reg, nbytes_reg);
`else
    assign last_blk = 1'b0;
    assign result   = core_result ^ data_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A key change always invalidates the counter, so it wins over iv_load and din.
    always_comb begin
        state_next = state;
        key_cap    = 1'b0;
        iv_cap     = 1'b0;
        accept     = 1'b0;
        core_cap   = 1'b0;
        out_hs     = 1'b0;
        case (state)
            S_IDLE: begin
                key_cap = key_load;
                if (iv_load) begin
                    iv_cap     = 1'b1;
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (key_load) begin
                    key_cap    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    iv_cap = iv_load;
                    if (din_valid && din_ready) begin
                        accept     = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    core_cap   = 1'b1;
                    state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (dout_ready) begin
                    out_hs     = 1'b1;
                    state_next = last_blk ? S_IDLE : S_READY;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ctr_next  = ctr_reg;
        wrap_next = ctr_wrap;
        if (iv_cap) begin
            ctr_next  = iv_i;
            wrap_next = 1'b0;
        end else if (core_cap) begin
            ctr_next  = inc_block;
            wrap_next = ctr_wrap | inc_wrap;
        end
    end

    // Every output is computed from next-state values so that none depends on an input combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_key   <= '0;
            ctr_reg    <= '0;
            ctr_wrap   <= 1'b0;
            data_reg   <= '0;
            din_ready  <= 1'b0;
            core_start <= 1'b0;
            core_block <= '0;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (key_cap) begin
                core_key <= key_i;
            end
            ctr_reg    <= ctr_next;
            ctr_wrap   <= wrap_next;
            din_ready  <= (state_next == S_READY) && !wrap_next;
            core_start <= accept;
            busy       <= (state_next == S_ISSUE) || (state_next == S_WAIT_CORE) ||
                          (state_next == S_OUTPUT);
            if (accept) begin
                data_reg   <= din;
                core_block <= ctr_next;
            end
            if (core_cap) begin
                dout       <= result;
                dout_valid <= 1'b1;
            end else if (out_hs) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef CTR_PARTIAL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_reg   <= 1'b0;
            nbytes_reg <= 4'd0;
            dout_last  <= 1'b0;
        end else begin
            if (accept) begin
                last_reg   <= din_last;
                nbytes_reg <= din_nbytes;
            end
            if (core_cap) begin
                dout_last <= last_reg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_ctr_controller.sv
// Self-checking bench for aes_ctr_controller; the bench plays the AES core and checks
// against a counter/keystream reference model. Covers CTR_PARTIAL_EN when defined.
module tb_aes_ctr_controller;

    localparam int CTR_W = 32;
`ifdef CTR_PARTIAL_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    localparam logic [255:0] NIST_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] NIST_IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] NIST_IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] NIST_P0   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] NIST_C0   = 128'h601ec313775789a5b7a7f504bbf3d228;
    localparam logic [127:0] NIST_P1   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] NIST_C1   = 128'hf443e3ca4d62b59aca84e990cacaf5c5;

    logic         clk;
    logic         rst;
    logic [255:0] key_i;
    logic         key_load;
    logic [127:0] iv_i;
    logic         iv_load;
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;
    logic         ctr_wrap;
`ifdef CTR_PARTIAL_EN
    logic         din_last;
    logic [3:0]   din_nbytes;
    logic         dout_last;
`endif

    int           vectors;
    int           miscompares;
    int           cycle;
    logic [255:0] m_key;
    logic [127:0] m_ctr;
    logic         m_wrap;
    logic         cur_last;
    logic [3:0]   cur_nbytes;
    logic [127:0] obs_dout;
    logic [127:0] obs_block;

    aes_ctr_controller #(.CTR_W(CTR_W)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CTR_PARTIAL_EN
        .din_last    (din_last),
        .din_nbytes  (din_nbytes),
        .dout_last   (dout_last),
`endif
        .key_i       (key_i),
        .key_load    (key_load),
        .iv_i        (iv_i),
        .iv_load     (iv_load),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .core_key    (core_key),
        .core_block  (core_block),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy),
        .ctr_wrap    (ctr_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] ctr_mask();
        logic [127:0] one;
        one = 128'd1;
        if (CTR_W >= 128) return '1;
        return (one << CTR_W) - one;
    endfunction

    // Counter block after n increments of its low CTR_W-bit field.
    function automatic logic [127:0] ctr_add(input logic [127:0] c, input int n);
        logic [127:0] m;
        m = ctr_mask();
        return (c & ~m) | ((c + 128'(n)) & m);
    endfunction

    // Stand-in AES core: real keystream for the two NIST blocks, otherwise a keyed mix.
    function automatic logic [127:0] ks_of(input logic [127:0] blk, input logic [255:0] k);
        if (k == NIST_KEY && blk == NIST_IV)  return NIST_P0 ^ NIST_C0;
        if (k == NIST_KEY && blk == NIST_IV1) return NIST_P1 ^ NIST_C1;
        return blk ^ k[255:128] ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] exp_out(input logic [127:0] raw, input logic [3:0] nb);
        int           keep;
        logic [127:0] m;
        if (!PARTIAL) return raw;
        keep = (nb == 4'd0) ? 16 : int'(nb);
        m    = '1;
        m    = m << (128 - 8 * keep);
        return raw & m;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [255:0] k, input logic [127:0] v, input bit dk, input bit dv);
        key_i    = k;
        iv_i     = v;
        key_load = dk;
        iv_load  = dv;
        tick();
        key_load = 1'b0;
        iv_load  = 1'b0;
        if (dk) m_key = k;
        if (dv) begin
            m_ctr  = v;
            m_wrap = 1'b0;
        end
    endtask

    task automatic setup(input logic [255:0] k, input logic [127:0] v);
        load(k, v, 1'b1, 1'b0);
        load(k, v, 1'b0, 1'b1);
    endtask

    // One block end to end; mode 1 also pulses key_load/iv_load with junk during WAIT_CORE.
    task automatic do_block(input logic [127:0] d, input int lat, input int bp, input int mode);
        int           waited;
        logic [127:0] ks;
        logic [127:0] expd;
        logic [127:0] held;
        logic         exp_rdy;
        din       = d;
        din_valid = 1'b1;
        waited    = 0;
        while (din_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL din_ready_wait: din_ready=%b, required 1 within 20 cycles", din_ready);
            din_valid = 1'b0;
            return;
        end
        tick();
        din_valid = 1'b0;
        vectors++;
        if (core_start !== 1'b1 || core_block !== m_ctr || core_key !== m_key || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL issue: start=%b block=%h key=%h busy=%b, required start=1 block=%h key=%h busy=1",
                     core_start, core_block, core_key, busy, m_ctr, m_key);
        end
        obs_block = core_block;
        ks        = ks_of(m_ctr, m_key);
        for (int i = 0; i < lat; i++) begin
            tick();
            key_load = 1'b0;
            iv_load  = 1'b0;
            vectors++;
            if (core_start !== 1'b0 || dout_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL wait_core: start=%b dout_valid=%b, required 0 0", core_start, dout_valid);
            end
            if (mode == 1 && i == 0) begin
                key_i    = {rand128(), rand128()};
                iv_i     = rand128();
                key_load = 1'b1;
                iv_load  = 1'b1;
            end
        end
        core_done   = 1'b1;
        core_result = ks;
        tick();
        core_done   = 1'b0;
        core_result = rand128();
        key_load    = 1'b0;
        iv_load     = 1'b0;
        expd = exp_out(d ^ ks, cur_nbytes);
        if ((m_ctr & ctr_mask()) == ctr_mask()) m_wrap = 1'b1;
        m_ctr = ctr_add(m_ctr, 1);
        vectors++;
        if (dout_valid !== 1'b1 || dout !== expd || din_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dout: valid=%b dout=%h din_ready=%b, required valid=1 dout=%h din_ready=0",
                     dout_valid, dout, din_ready, expd);
        end
        vectors++;
        if (ctr_wrap !== m_wrap || core_key !== m_key) begin
            miscompares++;
            $display("[TB] FAIL wrap_key: ctr_wrap=%b key=%h, required %b %h", ctr_wrap, core_key, m_wrap, m_key);
        end
`ifdef CTR_PARTIAL_EN
        vectors++;
        if (dout_last !== cur_last) begin
            miscompares++;
            $display("[TB] FAIL dout_last: got %b, required %b", dout_last, cur_last);
        end
`endif
        obs_dout = dout;
        held     = dout;
        for (int i = 0; i < bp; i++) begin
            tick();
            vectors++;
            if (dout !== held || dout_valid !== 1'b1 || din_ready !== 1'b0 || core_start !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL backpressure: dout=%h valid=%b din_ready=%b start=%b, required %h 1 0 0",
                         dout, dout_valid, din_ready, core_start, held);
            end
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        exp_rdy = !m_wrap && !(PARTIAL && cur_last);
        vectors++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== exp_rdy) begin
            miscompares++;
            $display("[TB] FAIL handshake: valid=%b busy=%b din_ready=%b, required 0 0 %b",
                     dout_valid, busy, din_ready, exp_rdy);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vectors++;
        if ({din_ready, dout_valid, core_start, busy, ctr_wrap} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, required 00000", {din_ready, dout_valid, core_start, busy, ctr_wrap});
        end
        vectors++;
        if (dout !== '0 || core_block !== '0 || core_key !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: dout=%h block=%h key=%h, required all 0", dout, core_block, core_key);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (din_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: din_ready=%b busy=%b, required 0 0", din_ready, busy);
        end
    endtask

    task automatic test_nist();
        load(NIST_KEY, NIST_IV, 1'b1, 1'b1);
        vectors++;
        if (core_key !== NIST_KEY || din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nist_load: key=%h din_ready=%b, required %h 1", core_key, din_ready, NIST_KEY);
        end
        do_block(NIST_P0, 2, 0, 0);
        vectors++;
        if (obs_dout !== NIST_C0) begin
            miscompares++;
            $display("[TB] FAIL nist_c0: got %h, required %h", obs_dout, NIST_C0);
        end
        do_block(NIST_P1, 3, 1, 0);
        vectors++;
        if (obs_block !== NIST_IV1 || obs_dout !== NIST_C1) begin
            miscompares++;
            $display("[TB] FAIL nist_c1: block=%h dout=%h, required %h %h", obs_block, obs_dout, NIST_IV1, NIST_C1);
        end
    endtask

    task automatic test_random_stream();
        logic [127:0] v;
        v = rand128();
        v[31:28] = 4'h0;
        setup({rand128(), rand128()}, v);
        for (int n = 0; n < 12; n++) begin
            do_block(rand128(), $urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 1));
        end
    endtask

    task automatic test_ignored_loads();
        logic [255:0] k0;
        k0 = m_key;
        do_block(rand128(), 3, 0, 1);
        vectors++;
        if (core_key !== k0) begin
            miscompares++;
            $display("[TB] FAIL ignored_key: got %h, required %h", core_key, k0);
        end
        do_block(rand128(), 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        int start;
        start = cycle;
        for (int n = 0; n < 4; n++) do_block(rand128(), 2, 0, 0);
        vectors++;
        if (cycle - start != 4 * (2 + 3)) begin
            miscompares++;
            $display("[TB] FAIL throughput: %0d cycles for 4 blocks, required %0d", cycle - start, 4 * 5);
        end
    endtask

    task automatic test_backpressure();
        do_block(rand128(), 2, 5, 0);
        do_block(rand128(), 1, 0, 0);
    endtask

    task automatic test_wrap();
        logic [127:0] v;
        v = rand128();
        v[31:0] = 32'hffffffff;
        load(m_key, v, 1'b0, 1'b1);
        do_block(rand128(), 2, 0, 0);
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (din_ready !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0 || ctr_wrap !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL wrap_halt: din_ready=%b start=%b busy=%b wrap=%b, required 0 0 0 1",
                         din_ready, core_start, busy, ctr_wrap);
            end
        end
        din_valid = 1'b0;
        v = rand128();
        v[31:28] = 4'h0;
        load(m_key, v, 1'b0, 1'b1);
        vectors++;
        if (ctr_wrap !== 1'b0 || din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_clear: wrap=%b din_ready=%b, required 0 1", ctr_wrap, din_ready);
        end
        do_block(rand128(), 1, 0, 0);
    endtask

    task automatic test_key_priority();
        logic [255:0] k;
        k         = {rand128(), rand128()};
        key_i     = k;
        key_load  = 1'b1;
        din       = rand128();
        din_valid = 1'b1;
        tick();
        key_load = 1'b0;
        m_key    = k;
        vectors++;
        if (core_start !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0 || core_key !== k) begin
            miscompares++;
            $display("[TB] FAIL key_priority: start=%b busy=%b din_ready=%b key=%h, required 0 0 0 %h",
                     core_start, busy, din_ready, core_key, k);
        end
        tick();
        din_valid = 1'b0;
        vectors++;
        if (core_start !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL key_idle: start=%b busy=%b, required 0 0", core_start, busy);
        end
    endtask

    task automatic test_reset_midflight();
        setup({rand128(), rand128()}, rand128() & ~ctr_mask());
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midflight_pre: din_ready=%b, required 1", din_ready);
        end
        din       = rand128();
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({din_ready, dout_valid, core_start, busy, ctr_wrap} !== 5'b0 || dout !== '0 ||
            core_key !== '0 || core_block !== '0) begin
            miscompares++;
            $display("[TB] FAIL midflight_reset: flags=%b dout=%h key=%h block=%h, required all 0",
                     {din_ready, dout_valid, core_start, busy, ctr_wrap}, dout, core_key, core_block);
        end
        m_key  = '0;
        m_ctr  = '0;
        m_wrap = 1'b0;
        tick();
        rst         = 1'b1;
        core_done   = 1'b1;
        core_result = rand128();
        tick();
        core_done = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dout_valid !== 1'b0 || din_ready !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midflight_idle: valid=%b din_ready=%b busy=%b start=%b, required 0 0 0 0",
                         dout_valid, din_ready, busy, core_start);
            end
        end
        din_valid = 1'b0;
        load(m_key, rand128() & ~ctr_mask(), 1'b0, 1'b1);
        vectors++;
        if (din_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midflight_iv: din_ready=%b, required 1", din_ready);
        end
        do_block(rand128(), 2, 0, 0);
    endtask

`ifdef CTR_PARTIAL_EN
    task automatic test_partial();
        setup({rand128(), rand128()}, rand128() & ~ctr_mask());
        do_block(rand128(), 1, 0, 0);
        cur_last   = 1'b1;
        cur_nbytes = 4'd5;
        din_last   = 1'b1;
        din_nbytes = 4'd5;
        do_block(rand128(), 2, 1, 0);
        vectors++;
        if (obs_dout[87:0] !== 88'h0) begin
            miscompares++;
            $display("[TB] FAIL partial_mask: dout[87:0]=%h, required 0", obs_dout[87:0]);
        end
        cur_last   = 1'b0;
        cur_nbytes = 4'd0;
        din_last   = 1'b0;
        din_nbytes = 4'd0;
        tick();
        vectors++;
        if (din_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL partial_idle: din_ready=%b busy=%b, required 0 0", din_ready, busy);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        rst         = 1'b0;
        key_i       = '0;
        key_load    = 1'b0;
        iv_i        = '0;
        iv_load     = 1'b0;
        din         = '0;
        din_valid   = 1'b0;
        dout_ready  = 1'b0;
        core_done   = 1'b0;
        core_result = '0;
        m_key       = '0;
        m_ctr       = '0;
        m_wrap      = 1'b0;
        cur_last    = 1'b0;
        cur_nbytes  = 4'd0;
`ifdef CTR_PARTIAL_EN
        din_last    = 1'b0;
        din_nbytes  = 4'd0;
`endif
        test_reset();
        test_nist();
        test_random_stream();
        test_ignored_loads();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_key_priority();
        test_reset_midflight();
`ifdef CTR_PARTIAL_EN
        test_partial();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
